// File: rtl/f1_light_seq_if.sv
// Bundled control and status signals for the F1 start-light sequencer.
// The master side drives en/trigger/hold_cycles; the slave (the sequencer) drives the rest.
interface f1_light_seq_if #(
    parameter int unsigned NUM_LIGHTS = 8,
    parameter int unsigned HOLD_W     = 16,
    parameter int unsigned REACT_W    = 16
);
    logic                  en;
    logic                  trigger;
    logic [HOLD_W-1:0]     hold_cycles;
    logic [NUM_LIGHTS-1:0] out;
    logic                  cmd_seq;
    logic                  cmd_delay;
    logic                  lights_out;
    logic                  jump_start;
    logic [REACT_W-1:0]    react_time;
    logic                  react_valid;

    modport master (
        output en, trigger, hold_cycles,
        input  out, cmd_seq, cmd_delay, lights_out, jump_start, react_time, react_valid
    );

    modport slave (
        input  en, trigger, hold_cycles,
        output out, cmd_seq, cmd_delay, lights_out, jump_start, react_time, react_valid
    );
endinterface

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: fill lights on en ticks, hold, lights out, jump-start detection.
// Define F1_REACTION_TIMER_EN to compile in the driver reaction timer (REACT state).
module f1_light_seq #(
    parameter int unsigned NUM_LIGHTS = 8,
    parameter int unsigned HOLD_W     = 16,
    parameter int unsigned REACT_W    = 16
) (
    input logic            clk,
    input logic            rst,
    f1_light_seq_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(NUM_LIGHTS + 1);

    typedef enum logic [1:0] {StIdle, StFill, StHold, StReact} state_e;

    state_e                state_q;
    logic                  trig_q;
    logic                  armed_q;
    logic [CNT_W-1:0]      count_q;
    logic [HOLD_W-1:0]     hold_q;
    logic [NUM_LIGHTS-1:0] out_q;
    logic                  cmd_seq_q;
    logic                  cmd_delay_q;
    logic                  lights_out_q;
    logic                  jump_start_q;
    logic                  trig_edge;

    // armed_q blocks a trigger held high through reset release from reading as an edge
    assign trig_edge = bus.trigger & ~trig_q & armed_q;

    function automatic logic [NUM_LIGHTS-1:0] therm(input logic [CNT_W-1:0] c);
        logic [NUM_LIGHTS-1:0] r;
        for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
            r[i] = (i < 32'(c));
        end
        return r;
    endfunction

`ifdef F1_REACTION_TIMER_EN
    logic [REACT_W-1:0] react_cnt_q;
    logic [REACT_W-1:0] react_time_q;
    logic               react_valid_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            trig_q       <= 1'b0;
            armed_q      <= 1'b0;
            count_q      <= '0;
            hold_q       <= '0;
            out_q        <= '0;
            cmd_seq_q    <= 1'b0;
            cmd_delay_q  <= 1'b0;
            lights_out_q <= 1'b0;
            jump_start_q <= 1'b0;
`ifdef F1_REACTION_TIMER_EN
            react_cnt_q   <= '0;
            react_time_q  <= '0;
            react_valid_q <= 1'b0;
`endif
        end else begin
            trig_q       <= bus.trigger;
            lights_out_q <= 1'b0;
            jump_start_q <= 1'b0;
            if (!bus.trigger) begin
                armed_q <= 1'b1;
            end
`ifdef F1_REACTION_TIMER_EN
            react_valid_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (trig_edge) begin
                        state_q   <= StFill;
                        count_q   <= '0;
                        out_q     <= '0;
                        cmd_seq_q <= 1'b1;
                    end
                end
                StFill: begin
                    if (bus.en) begin
                        if (count_q == CNT_W'(NUM_LIGHTS - 1)) begin
                            state_q     <= StHold;
                            count_q     <= CNT_W'(NUM_LIGHTS);
                            out_q       <= '1;
                            cmd_seq_q   <= 1'b0;
                            cmd_delay_q <= 1'b1;
                            hold_q      <= bus.hold_cycles;
                        end else begin
                            count_q <= count_q + 1'b1;
                            out_q   <= therm(count_q + 1'b1);
                        end
                    end
                end
                StHold: begin
                    if (trig_edge) begin
                        state_q      <= StIdle;
                        count_q      <= '0;
                        hold_q       <= '0;
                        out_q        <= '0;
                        cmd_delay_q  <= 1'b0;
                        jump_start_q <= 1'b1;
                    end else if (bus.en) begin
                        if (hold_q != '0) begin
                            hold_q <= hold_q - 1'b1;
                        end else begin
                            count_q      <= '0;
                            out_q        <= '0;
                            cmd_delay_q  <= 1'b0;
                            lights_out_q <= 1'b1;
`ifdef F1_REACTION_TIMER_EN
                            state_q      <= StReact;
                            react_cnt_q  <= '0;
`else
                            state_q      <= StIdle;
`endif
                        end
                    end
                end
`ifdef F1_REACTION_TIMER_EN
                StReact: begin
                    if (trig_edge) begin
                        state_q       <= StIdle;
                        react_time_q  <= react_cnt_q;
                        react_valid_q <= 1'b1;
                    end else if (react_cnt_q != '1) begin
                        react_cnt_q <= react_cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.out        = out_q;
    assign bus.cmd_seq    = cmd_seq_q;
    assign bus.cmd_delay  = cmd_delay_q;
    assign bus.lights_out = lights_out_q;
    assign bus.jump_start = jump_start_q;
`ifdef F1_REACTION_TIMER_EN
    assign bus.react_time  = react_time_q;
    assign bus.react_valid = react_valid_q;
`else
    assign bus.react_time  = '0;
    assign bus.react_valid = 1'b0;
`endif
endmodule

// File: tb/tb_f1_light_seq.sv
// Directed self-checking bench for f1_light_seq: an 8-light unit and a 5-light / 4-bit-timer unit.
module tb_f1_light_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    f1_light_seq_if #(.NUM_LIGHTS(8), .HOLD_W(16), .REACT_W(16)) bus_a ();
    f1_light_seq_if #(.NUM_LIGHTS(5), .HOLD_W(16), .REACT_W(4))  bus_b ();

    f1_light_seq #(.NUM_LIGHTS(8), .HOLD_W(16), .REACT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    f1_light_seq #(.NUM_LIGHTS(5), .HOLD_W(16), .REACT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {cmd_seq, cmd_delay, lights_out, jump_start, out}
    function automatic logic [11:0] st_a;
        return {bus_a.cmd_seq, bus_a.cmd_delay, bus_a.lights_out, bus_a.jump_start, bus_a.out};
    endfunction

    function automatic logic [8:0] st_b;
        return {bus_b.cmd_seq, bus_b.cmd_delay, bus_b.lights_out, bus_b.jump_start, bus_b.out};
    endfunction

    logic [7:0] e;
    logic       seen;
    logic [4:0] b_exp [0:6];

    initial begin
        checks = 0;
        errors = 0;
        b_exp = '{5'h00, 5'h01, 5'h03, 5'h07, 5'h0F, 5'h1F, 5'h00};
        rst = 1'b1;
        bus_a.en = 1'b1; bus_a.trigger = 1'b0; bus_a.hold_cycles = 16'd3;
        bus_b.en = 1'b0; bus_b.trigger = 1'b0; bus_b.hold_cycles = 16'd0;
        tick;
        tick;
        check("reset_a", {20'h0, st_a()}, 32'h0);
        check("reset_a_react", {bus_a.react_valid, bus_a.react_time}, 32'h0);
        check("reset_b", {23'h0, st_b()}, 32'h0);
        rst = 1'b0;
        tick;

        // Full sequence, en always high, hold 3
        bus_a.trigger = 1'b1;
        tick;
        bus_a.trigger = 1'b0;
        check("fill_0", {20'h0, st_a()}, {20'h0, 4'b1000, 8'h00});
        for (int i = 1; i < 8; i++) begin
            tick;
            e = 8'((1 << i) - 1);
            check("fill_step", {20'h0, st_a()}, {20'h0, 4'b1000, e});
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            check("hold_ff", {20'h0, st_a()}, {20'h0, 4'b0100, 8'hFF});
        end
        tick;
        check("lights_out", {20'h0, st_a()}, {20'h0, 4'b0010, 8'h00});
`ifdef F1_REACTION_TIMER_EN
        repeat (10) tick;
        check("react_no_valid_yet", {31'h0, bus_a.react_valid}, 32'h0);
        bus_a.trigger = 1'b1;
        tick;
        bus_a.trigger = 1'b0;
        check("react_10", {bus_a.react_valid, bus_a.react_time}, {15'h0, 1'b1, 16'd10});
        tick;
        check("react_hold", {bus_a.react_valid, bus_a.react_time}, {15'h0, 1'b0, 16'd10});
        check("react_idle", {20'h0, st_a()}, 32'h0);
`else
        tick;
        check("post_lo_idle", {19'h0, bus_a.react_valid, st_a()}, 32'h0);
        bus_a.trigger = 1'b1;
        tick;
        bus_a.trigger = 1'b0;
        check("idle_refill", {20'h0, st_a()}, {20'h0, 4'b1000, 8'h00});
        check("no_react", {bus_a.react_valid, bus_a.react_time}, 32'h0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
`endif

        // Reset mid-HOLD with trigger held high
        bus_a.hold_cycles = 16'd10;
        bus_a.trigger = 1'b1;
        tick;
        bus_a.trigger = 1'b0;
        repeat (8) tick;
        check("mid_hold", {20'h0, st_a()}, {20'h0, 4'b0100, 8'hFF});
        rst = 1'b1;
        bus_a.trigger = 1'b1;
        tick;
        check("rst_hold", {20'h0, st_a()}, 32'h0);
        check("rst_react", {bus_a.react_valid, bus_a.react_time}, 32'h0);
        rst = 1'b0;
        repeat (3) tick;
        check("held_trig_no_fill", {20'h0, st_a()}, 32'h0);
        bus_a.trigger = 1'b0;
        tick;
        bus_a.trigger = 1'b1;
        tick;
        bus_a.trigger = 1'b0;
        check("rearmed_fill", {20'h0, st_a()}, {20'h0, 4'b1000, 8'h00});

        // Trigger ignored in FILL, jump start in HOLD
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus_a.hold_cycles = 16'd5;
        tick;
        bus_a.trigger = 1'b1;
        tick;
        bus_a.trigger = 1'b0;
        tick;
        bus_a.trigger = 1'b1;
        tick;
        bus_a.trigger = 1'b0;
        tick;
        check("fill_trig_ignored", {20'h0, st_a()}, {20'h0, 4'b1000, 8'h07});
        repeat (5) tick;
        check("js_hold", {20'h0, st_a()}, {20'h0, 4'b0100, 8'hFF});
        bus_a.trigger = 1'b1;
        tick;
        bus_a.trigger = 1'b0;
        check("jump_start", {20'h0, st_a()}, {20'h0, 4'b0001, 8'h00});
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            seen = seen | bus_a.lights_out | bus_a.jump_start | bus_a.cmd_delay;
        end
        check("js_no_lights_out", {31'h0, seen}, 32'h0);

        // 5 lights, en every 4th cycle, hold 0
        bus_b.trigger = 1'b1;
        tick;
        bus_b.trigger = 1'b0;
        check("b_fill0", {23'h0, st_b()}, {23'h0, 4'b1000, 5'h00});
        for (int g = 1; g <= 6; g++) begin
            bus_b.en = 1'b0;
            repeat (3) tick;
            check("b_en_low", {27'h0, bus_b.out}, {27'h0, b_exp[g-1]});
            bus_b.en = 1'b1;
            tick;
            bus_b.en = 1'b0;
            check("b_en_tick", {27'h0, bus_b.out}, {27'h0, b_exp[g]});
            if (g == 5) check("b_hold", {23'h0, st_b()}, {23'h0, 4'b0100, 5'h1F});
        end
        check("b_lights_out", {23'h0, st_b()}, {23'h0, 4'b0010, 5'h00});
`ifdef F1_REACTION_TIMER_EN
        repeat (30) tick;
        bus_b.trigger = 1'b1;
        tick;
        bus_b.trigger = 1'b0;
        check("b_react_sat", {bus_b.react_valid, bus_b.react_time}, {27'h0, 1'b1, 4'd15});
`else
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            seen = seen | bus_b.react_valid | (bus_b.react_time != 4'd0);
        end
        check("b_no_react", {31'h0, seen}, 32'h0);
        check("b_idle", {23'h0, st_b()}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
